cnn_top: RTL and testbench
==========================

# cnn_top

Streaming LeNet-style inference core: one 8-bit input bus carries first a 54-byte weight set, then a continuous stream of 11×11 8-bit images. For each image it computes a 3-kernel 3×3 convolution with ReLU, 3×3 max-pooling and a 27-input fully-connected neuron, and emits one 8-bit result per image. It is the chip's top compute block, fed directly from the input pads.

## Interface
- No parameters. Fixed geometry: image 11×11, 3 kernels 3×3, conv map 9×9, pool 3×3 stride 3, FC 27→1.
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  reset: synchronous and active-low.
- mode  in  1  1 = in_data carries a weight byte; 0 = in_data carries a pixel.
- work_flag  in  1  qualifies in_data; a byte is consumed on each rising edge where work_flag=1.
- in_data  in  8  weight (signed two's complement) or pixel (unsigned).
- out_now  out  1  one-cycle pulse marking a valid result.
- out_data  out  8  result byte (unsigned), held until the next pulse.

## Operation
- Weight load (work_flag=1, mode=1): byte goes to weight[wptr], and wptr increments. wptr runs 0..53. Bytes arriving when wptr=54 are ignored.
- Weight layout: index k*9+r*3+c is conv kernel k (0..2), row r, column c. Index 27+k*9+a*3+b is the FC weight for pool cell (a,b) of map k.
- A weight-mode byte resets the pixel counter, which discards any partial image.
- Pixel load (work_flag=1, mode=0): pixels arrive raster order, p[r][c], index r*11+c. The pixel counter wraps 120→0, and images are back-to-back with no gap.
- Cycles with work_flag=0 consume nothing and freeze the input-side state. Results for an image are unchanged by gaps inside it.
- Conv: s[k][i][j] = Σ w[k][r][c]·p[i+r][j+c], for i,j in 0..8. Products are u8×s8, and the sum is signed with at least 20 bits, no overflow.
- Feature: f = min(255, max(0,s) >> 8). This is ReLU, logical shift right 8, then saturate to 8 bits.
- Pool: m[k][a][b] = max of f over i in 3a..3a+2 and j in 3b..3b+2.
- FC: t = Σ wfc[k][a][b]·m[k][a][b] over 27 terms, signed, at least 20 bits.
- Output: out_data = min(255, max(0,t) >> 8).
- Implementation: 2-row line buffer plus 3×3 window, 27 parallel multipliers, running max registers per pool cell, and an FC accumulator. It must sustain 1 pixel/clock indefinitely.
- Reset clears all weights to 0, wptr, pixel counter, window/pool/FC state and pipeline; out_now=0, out_data=0. Reset mid-image discards that image, and no pulse is produced for it.

## Timing
- Inputs are sampled on the rising edge where work_flag=1.
- Latency: if pixel 120 of an image is sampled at edge E, then at edge E+4 out_now goes to 1 and out_data is loaded. out_now returns to 0 at E+5.
- Exactly one pulse per complete image, in input order. Back-to-back images give pulses exactly 121 cycles apart.
- The pipeline drains with work_flag=0: a pending result still emerges 4 edges after its last pixel, whatever work_flag does afterwards.
- Reset values: out_now=0, out_data=0.

## Test plan
- Saturation path: kernel0 weights all 127, other conv weights 0; FC weight 27 = 127, other FC weights 0; image all 255. Required: out_data=126 (conv 291465→255, FC 255·127=32385>>8), out_now pulse 4 edges after the last pixel.
- ReLU: same image, kernel0 weights all −1 (0xFF), any FC weights → out_data=0. Separately, positive conv weights with FC weights all −128 → out_data=0.
- Pool position: p[5][5]=255, else 0; weight 4 = 127 (kernel0 centre); FC weight 31 = 127 (map0 cell (1,1)); all other weights 0. Required: out_data=62.
- Stream: 54 weights followed by 100 back-to-back images (12100 cycles), then work_flag=0 for 500 cycles. Required: exactly 100 pulses, 121 cycles apart, all values matching a golden model of the arithmetic above.
- Gap: insert 10 work_flag=0 cycles mid-image → same out_data as the gapless run; the pulse is delayed by 10 cycles.
- Reset mid-image: rst_n=0 for one edge at pixel 60. Required: out_now=0 and out_data=0 after that edge, no pulse for the aborted image, and weights read back as 0 (a new image gives out_data=0 until weights are reloaded).

Source files
------------

// File: rtl/cnn_top.sv
// Streaming 11x11 image classifier core: 3x 3x3 conv + ReLU, 3x3 max-pool, 27->1 FC.
// One byte per clock in; one result pulse 4 edges after each image's last pixel.
module cnn_top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic       work_flag,
  input  logic [7:0] in_data,
  output logic       out_now,
  output logic [7:0] out_data
);

  logic [7:0]        r_w [54];
  logic [5:0]        r_wptr;
  logic [3:0]        r_row, r_col;
  logic [7:0]        r_sr [25];
  logic              r_v1, r_last1;
  logic [3:0]        r_i1, r_j1;
  logic [7:0]        r_f [3];
  logic              r_v2, r_first2, r_last2;
  logic [1:0]        r_a2, r_b2;
  logic [7:0]        r_m [27];
  logic              r_v3, r_v4;
  logic signed [21:0] r_t;

  logic signed [21:0] w_conv [3];
  logic signed [21:0] w_fc;
  logic [3:0]         w_cell;

  function automatic logic signed [21:0] mul_us(input logic [7:0] p, input logic [7:0] w);
    logic signed [21:0] pe, we;
    pe = signed'({14'd0, p});
    we = signed'({{14{w[7]}}, w});
    return pe * we;
  endfunction

  // ReLU, >>8, saturate to a byte
  function automatic logic [7:0] sat8(input logic signed [21:0] v);
    logic signed [21:0] sh;
    sh = v >>> 8;
    if (v < 0)
      return 8'd0;
    else if (sh > 22'sd255)
      return 8'd255;
    else
      return sh[7:0];
  endfunction

  function automatic logic [1:0] div3(input logic [3:0] i);
    return (i >= 4'd6) ? 2'd2 : (i >= 4'd3) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic is_mul3(input logic [3:0] i);
    return (i == 4'd0) || (i == 4'd3) || (i == 4'd6);
  endfunction

  // Input side: weight store, pixel counter and the 2-row + 3-pixel shift line buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_i1    <= '0;
      r_j1    <= '0;
      for (int i = 0; i < 54; i++) r_w[i] <= '0;
      for (int i = 0; i < 25; i++) r_sr[i] <= '0;
    end else begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      if (work_flag && mode) begin
        if (r_wptr != 6'd54) begin
          r_w[r_wptr] <= in_data;
          r_wptr      <= r_wptr + 6'd1;
        end
        r_row <= '0;
        r_col <= '0;
      end else if (work_flag) begin
        for (int i = 24; i > 0; i--) r_sr[i] <= r_sr[i-1];
        r_sr[0] <= in_data;
        r_v1    <= (r_row >= 4'd2) && (r_col >= 4'd2);
        r_last1 <= (r_row == 4'd10) && (r_col == 4'd10);
        r_i1    <= r_row - 4'd2;
        r_j1    <= r_col - 4'd2;
        if (r_col == 4'd10) begin
          r_col <= '0;
          r_row <= (r_row == 4'd10) ? 4'd0 : r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
    end
  end

  // Window tap (r,c) sits (2-r) rows and (2-c) pixels behind the newest pixel
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_conv[k] = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_conv[k] = w_conv[k] + mul_us(r_sr[(2-r)*11 + (2-c)], r_w[k*9 + r*3 + c]);
    end
  end

  always_comb begin
    w_fc = '0;
    for (int n = 0; n < 27; n++)
      w_fc = w_fc + mul_us(r_m[n], r_w[27 + n]);
  end

  assign w_cell = {2'b0, r_a2} * 4'd3 + {2'b0, r_b2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_first2 <= 1'b0;
      r_last2  <= 1'b0;
      r_a2     <= '0;
      r_b2     <= '0;
      r_v3     <= 1'b0;
      r_v4     <= 1'b0;
      r_t      <= '0;
      out_now  <= 1'b0;
      out_data <= '0;
      for (int k = 0; k < 3; k++) r_f[k] <= '0;
      for (int n = 0; n < 27; n++) r_m[n] <= '0;
    end else begin
      r_v2     <= r_v1;
      r_last2  <= r_v1 && r_last1;
      r_a2     <= div3(r_i1);
      r_b2     <= div3(r_j1);
      r_first2 <= is_mul3(r_i1) && is_mul3(r_j1);
      for (int k = 0; k < 3; k++) r_f[k] <= sat8(w_conv[k]);
      // First feature of a pool cell overwrites, so the previous image never leaks in
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 9; c++)
          if (r_v2 && (w_cell == 4'(c)))
            r_m[k*9 + c] <= (r_first2 || (r_f[k] > r_m[k*9 + c])) ? r_f[k] : r_m[k*9 + c];
      r_v3    <= r_last2;
      r_v4    <= r_v3;
      r_t     <= w_fc;
      out_now <= r_v4;
      if (r_v4) out_data <= sat8(r_t);
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// Randomized and directed checks of cnn_top against a plain-arithmetic reference model.
module tb_cnn_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic       work_flag = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_now;
  logic [7:0] out_data;

  cnn_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .work_flag(work_flag),
    .in_data  (in_data),
    .out_now  (out_now),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int edge_n;
    int val;
  } exp_t;

  exp_t       expq[$];
  exp_t       e_mon;
  exp_t       e_drv;
  logic [7:0] m_w [54];
  logic [7:0] img [121];
  int         last_out = -1;
  int         prev_edge = -1;
  int         n_pulses = 0;
  bit         spacing_on = 0;

  always @(negedge clk) begin
    if (out_now === 1'b1) begin
      n_pulses++;
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e_mon = expq.pop_front();
        chk("out_data", int'(out_data), e_mon.val);
        chk("pulse_edge", cyc, e_mon.edge_n);
        if (spacing_on && prev_edge >= 0) chk("spacing", cyc - prev_edge, 121);
        prev_edge = cyc;
        last_out  = int'(out_data);
      end
    end
  end

  function automatic int sat(input int v);
    if (v < 0) return 0;
    return ((v >> 8) > 255) ? 255 : (v >> 8);
  endfunction

  function automatic int model();
    int f [3][9][9];
    int s, t, mx;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 9; i++)
        for (int j = 0; j < 9; j++) begin
          s = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              s += int'(img[(i+r)*11 + j + c]) * int'($signed(m_w[k*9 + r*3 + c]));
          f[k][i][j] = sat(s);
        end
    t = 0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++) begin
          mx = 0;
          for (int i = 3*a; i < 3*a + 3; i++)
            for (int j = 3*b; j < 3*b + 3; j++)
              if (f[k][i][j] > mx) mx = f[k][i][j];
          t += mx * int'($signed(m_w[27 + k*9 + a*3 + b]));
        end
    return sat(t);
  endfunction

  task automatic drive(input logic m, input logic [7:0] d);
    @(negedge clk);
    mode      = m;
    in_data   = d;
    work_flag = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      work_flag = 1'b0;
      mode      = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    work_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_w();
    for (int i = 0; i < 54; i++) m_w[i] = 8'd0;
  endtask

  task automatic load_weights();
    for (int i = 0; i < 54; i++) drive(1'b1, m_w[i]);
  endtask

  task automatic send_pixels(input int n, input int gap_at, input int gap_len);
    for (int p = 0; p < n; p++) begin
      if (p == gap_at) idle(gap_len);
      drive(1'b0, img[p]);
      if (p == 120) begin
        e_drv.edge_n = cyc + 1 + 4;
        e_drv.val    = model();
        expq.push_back(e_drv);
      end
    end
  endtask

  task automatic fill_img(input int v);
    for (int p = 0; p < 121; p++) img[p] = 8'(v);
  endtask

  task automatic rand_img();
    for (int p = 0; p < 121; p++) img[p] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_w();
    for (int i = 0; i < 54; i++) m_w[i] = 8'($urandom_range(0, 255));
  endtask

  int g0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_now", int'(out_now), 0);
    chk("reset_out_data", int'(out_data), 0);
    rst_n = 1'b1;

    // saturation path
    clear_w();
    for (int i = 0; i < 9; i++) m_w[i] = 8'd127;
    m_w[27] = 8'd127;
    do_reset();
    load_weights();
    fill_img(255);
    send_pixels(121, -1, 0);
    idle(10);
    chk("sat_value", last_out, 126);

    // ReLU on conv output
    clear_w();
    for (int i = 0; i < 9; i++) m_w[i] = 8'hFF;
    for (int i = 27; i < 54; i++) m_w[i] = 8'($urandom_range(0, 255));
    do_reset();
    load_weights();
    send_pixels(121, -1, 0);
    idle(10);
    chk("relu_conv", last_out, 0);

    // ReLU on FC output
    clear_w();
    for (int i = 0; i < 27; i++) m_w[i] = 8'($urandom_range(1, 127));
    for (int i = 27; i < 54; i++) m_w[i] = 8'h80;
    do_reset();
    load_weights();
    send_pixels(121, -1, 0);
    idle(10);
    chk("relu_fc", last_out, 0);

    // pool position
    clear_w();
    m_w[4]  = 8'd127;
    m_w[31] = 8'd127;
    do_reset();
    load_weights();
    fill_img(0);
    img[5*11 + 5] = 8'd255;
    send_pixels(121, -1, 0);
    idle(10);
    chk("pool_pos", last_out, 62);

    // gap inside an image must not change the result
    rand_w();
    do_reset();
    load_weights();
    rand_img();
    send_pixels(121, -1, 0);
    idle(10);
    g0 = last_out;
    send_pixels(121, 50, 10);
    idle(10);
    chk("gap_same", last_out, g0);

    // weight bytes past 54 are ignored but still discard a partial image
    send_pixels(40, -1, 0);
    drive(1'b1, 8'h5A);
    drive(1'b1, 8'hA5);
    rand_img();
    send_pixels(121, -1, 0);
    idle(10);

    // 100 back-to-back images
    rand_w();
    do_reset();
    load_weights();
    n_pulses   = 0;
    prev_edge  = -1;
    spacing_on = 1;
    for (int n = 0; n < 100; n++) begin
      rand_img();
      send_pixels(121, -1, 0);
    end
    idle(500);
    spacing_on = 0;
    chk("stream_count", n_pulses, 100);

    // reset in the middle of an image
    clear_w();
    for (int i = 0; i < 9; i++) m_w[i] = 8'd127;
    m_w[27] = 8'd127;
    do_reset();
    load_weights();
    fill_img(255);
    send_pixels(60, -1, 0);
    @(negedge clk);
    rst_n     = 1'b0;
    work_flag = 1'b0;
    @(negedge clk);
    chk("midreset_out_now", int'(out_now), 0);
    chk("midreset_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    clear_w();
    idle(10);
    send_pixels(121, -1, 0);
    idle(20);
    chk("after_reset_value", last_out, 0);

    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
